// File: rtl/ctrl_status_disp.sv
// ---------------------------------------------------------------------------
// ctrl_status_disp
//
// Front-panel status display driver for the multicycle CPU. Once per display
// frame it snapshots the controller status (state, instruction type, opcode
// code and stage). It decodes each field into a 7-segment glyph and scans the
// four digits of a common-anode multiplexed display.
//
// Digit assignment (an_n bit = digit index):
//   digit 3 : instruction type   (n, r, J, I)
//   digit 2 : opcode code        (0, L, S, A, U, a, o, J)
//   digit 1 : stage              (1..5 for IF..WB)
//   digit 0 : raw controller state as a hex glyph; dp lit for state 4'hF
// An out-of-range type, code or stage shows a dash and raises code_err.
//
// Parameters
//   SCAN_DIV   : clk cycles each digit stays lit (2..65535)
//
// Ports
//   clk        : system clock (same clock as the controller)
//   rst        : asynchronous, active-high reset
//   state      : controller FSM state code
//   insn_type  : instruction type code
//   insn_code  : opcode code
//   insn_stage : pipeline stage code
//   seg_n      : segments {g,f,e,d,c,b,a}, active-low, registered
//   dp_n       : decimal point, active-low, registered
//   an_n       : digit enables, active-low one-hot, registered
//   code_err   : current snapshot holds an invalid field, registered
//
// Build option
//   CTRL_DISP_BLINK_EN : when defined, digits whose field is in error are
//                        blanked during the second half of every 64-frame
//                        period. When undefined they show a steady dash.
// ---------------------------------------------------------------------------
module ctrl_status_disp #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic [3:0] insn_type,
  input  logic [3:0] insn_code,
  input  logic [2:0] insn_stage,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [3:0] an_n,
  output logic       code_err
);

  // Active-high glyph patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_ZERO = 7'h3F;
  localparam logic [6:0] GLYPH_UA   = 7'h77;
  localparam logic [6:0] GLYPH_LA   = 7'h5F;
  localparam logic [6:0] GLYPH_R    = 7'h50;
  localparam logic [6:0] GLYPH_J    = 7'h1E;
  localparam logic [6:0] GLYPH_I    = 7'h06;
  localparam logic [6:0] GLYPH_N    = 7'h54;
  localparam logic [6:0] GLYPH_L    = 7'h38;
  localparam logic [6:0] GLYPH_S    = 7'h6D;
  localparam logic [6:0] GLYPH_U    = 7'h3E;
  localparam logic [6:0] GLYPH_O    = 7'h5C;
  localparam logic [6:0] GLYPH_DASH = 7'h40;

  localparam logic [15:0] PRE_LAST = SCAN_DIV - 16'd1;

  // Hex digit glyphs 0..F, used for the raw state digit.
  function automatic logic [6:0] hexGlyph(input logic [3:0] value);
    logic [6:0] glyph;
    case (value)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
    return glyph;
  endfunction

  // Field decoders return {error, glyph}; an error always shows a dash.
  function automatic logic [7:0] typeDecode(input logic [3:0] code);
    logic [7:0] result;
    case (code)
      4'd0:    result = {1'b0, GLYPH_N};
      4'd1:    result = {1'b0, GLYPH_R};
      4'd2:    result = {1'b0, GLYPH_J};
      4'd3:    result = {1'b0, GLYPH_I};
      default: result = {1'b1, GLYPH_DASH};
    endcase
    return result;
  endfunction

  function automatic logic [7:0] codeDecode(input logic [3:0] code);
    logic [7:0] result;
    case (code)
      4'd0:    result = {1'b0, GLYPH_ZERO};
      4'd1:    result = {1'b0, GLYPH_L};
      4'd2:    result = {1'b0, GLYPH_S};
      4'd3:    result = {1'b0, GLYPH_UA};
      4'd4:    result = {1'b0, GLYPH_U};
      4'd5:    result = {1'b0, GLYPH_LA};
      4'd6:    result = {1'b0, GLYPH_O};
      4'd7:    result = {1'b0, GLYPH_J};
      default: result = {1'b1, GLYPH_DASH};
    endcase
    return result;
  endfunction

  // Stages are shown 1-based (IF=1 .. WB=5) to match the panel legend.
  function automatic logic [7:0] stageDecode(input logic [2:0] code);
    logic [7:0] result;
    case (code)
      3'd0:    result = {1'b0, 7'h06};
      3'd1:    result = {1'b0, 7'h5B};
      3'd2:    result = {1'b0, 7'h4F};
      3'd3:    result = {1'b0, 7'h66};
      3'd4:    result = {1'b0, 7'h6D};
      default: result = {1'b1, GLYPH_DASH};
    endcase
    return result;
  endfunction

  // Scan timing state
  logic [15:0] r_pre;
  logic [1:0]  r_idx;

  // Status snapshot, held for a whole frame
  logic [3:0]  r_snapState;
  logic [3:0]  r_snapType;
  logic [3:0]  r_snapCode;
  logic [2:0]  r_snapStage;

  // Registered display outputs
  logic [6:0]  r_seg;
  logic        r_dp;
  logic [3:0]  r_an;
  logic        r_codeErr;

  logic        w_tc;
  logic        w_frameEdge;
  logic [1:0]  w_idxNext;
  logic [3:0]  w_snapStateNext;
  logic [3:0]  w_snapTypeNext;
  logic [3:0]  w_snapCodeNext;
  logic [2:0]  w_snapStageNext;
  logic [7:0]  w_typeDec;
  logic [7:0]  w_codeDec;
  logic [7:0]  w_stageDec;
  logic        w_errNext;
  logic [6:0]  w_glyphNext;
  logic        w_blankNext;
  logic [3:0]  w_anNext;
  logic        w_dpNext;

  assign w_tc        = (r_pre == PRE_LAST);
  assign w_frameEdge = w_tc && (r_idx == 2'd3);
  assign w_idxNext   = r_idx + 2'd1;

  // The output registers load from the snapshot as it will be after this
  // edge. Digit 0 of a new frame therefore already reflects the inputs
  // sampled on the same frame-boundary edge.
  assign w_snapStateNext = w_frameEdge ? state      : r_snapState;
  assign w_snapTypeNext  = w_frameEdge ? insn_type  : r_snapType;
  assign w_snapCodeNext  = w_frameEdge ? insn_code  : r_snapCode;
  assign w_snapStageNext = w_frameEdge ? insn_stage : r_snapStage;

  assign w_typeDec  = typeDecode(w_snapTypeNext);
  assign w_codeDec  = codeDecode(w_snapCodeNext);
  assign w_stageDec = stageDecode(w_snapStageNext);
  assign w_errNext  = w_typeDec[7] | w_codeDec[7] | w_stageDec[7];

  // Pick the glyph for the digit that becomes active at the next TC.
  always_comb begin
    w_glyphNext = hexGlyph(w_snapStateNext);
    case (w_idxNext)
      2'd1:    w_glyphNext = w_stageDec[6:0];
      2'd2:    w_glyphNext = w_codeDec[6:0];
      2'd3:    w_glyphNext = w_typeDec[6:0];
      default: w_glyphNext = hexGlyph(w_snapStateNext);
    endcase
  end

`ifdef CTRL_DISP_BLINK_EN
  logic [5:0] r_frm;
  logic [5:0] w_frmNext;
  logic       w_fieldErr;

  // Blink phase follows the frame count as it will be after this edge, so the
  // first digit of frame 32 is already blanked.
  assign w_frmNext = w_frameEdge ? (r_frm + 6'd1) : r_frm;

  // Error flag of the field shown in the upcoming slot; the state digit
  // can never be in error.
  always_comb begin
    w_fieldErr = 1'b0;
    case (w_idxNext)
      2'd1:    w_fieldErr = w_stageDec[7];
      2'd2:    w_fieldErr = w_codeDec[7];
      2'd3:    w_fieldErr = w_typeDec[7];
      default: w_fieldErr = 1'b0;
    endcase
  end

  assign w_blankNext = w_errNext && w_frmNext[5] && w_fieldErr;

  // Frame counter, only needed to time the blink.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frm <= 6'd0;
    end else if (w_frameEdge) begin
      r_frm <= r_frm + 6'd1;
    end
  end
`else
  assign w_blankNext = 1'b0;
`endif

  assign w_anNext = w_blankNext ? 4'b1111 : ~(4'b0001 << w_idxNext);
  assign w_dpNext = !((w_idxNext == 2'd0) && (w_snapStateNext == 4'hF));

  // Prescaler and digit index: one digit slot every SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= 16'd0;
      r_idx <= 2'd0;
    end else if (w_tc) begin
      r_pre <= 16'd0;
      r_idx <= w_idxNext;
    end else begin
      r_pre <= r_pre + 16'd1;
    end
  end

  // Snapshot and error flag change only at the frame boundary so that all
  // four digits of a frame describe the same controller status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snapState <= 4'd0;
      r_snapType  <= 4'd0;
      r_snapCode  <= 4'd0;
      r_snapStage <= 3'd0;
      r_codeErr   <= 1'b0;
    end else if (w_frameEdge) begin
      r_snapState <= state;
      r_snapType  <= insn_type;
      r_snapCode  <= insn_code;
      r_snapStage <= insn_stage;
      r_codeErr   <= w_errNext;
    end
  end

  // Display outputs reload together on each TC, so an_n steps directly
  // from one one-hot-low value to the next and never shows two digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b1110;
      r_seg <= ~GLYPH_ZERO;
      r_dp  <= 1'b1;
    end else if (w_tc) begin
      r_an  <= w_anNext;
      r_seg <= ~w_glyphNext;
      r_dp  <= w_dpNext;
    end
  end

  assign seg_n    = r_seg;
  assign dp_n     = r_dp;
  assign an_n     = r_an;
  assign code_err = r_codeErr;

endmodule

// File: tb/tb_ctrl_status_disp.sv
// ---------------------------------------------------------------------------
// tb_ctrl_status_disp
//
// Directed bench for ctrl_status_disp with SCAN_DIV=4 (16-cycle frames).
// Every stimulus pushes the digit patterns the next frame should show into a
// scoreboard queue; the checker pops one entry per digit slot and compares
// every cycle of that slot. Expected glyphs come from the bench's own
// decode tables. Build with CTRL_DISP_BLINK_EN to expect blanking.
// ---------------------------------------------------------------------------
module tb_ctrl_status_disp;

  localparam logic [15:0] DIV       = 16'd4;
  localparam int          FRAME_CYC = 16;
`ifdef CTRL_DISP_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state;
  logic [3:0] insn_type;
  logic [3:0] insn_code;
  logic [2:0] insn_stage;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic       code_err;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       err;
    bit         chkSeg;
  } expT;

  expT sbQ[$];
  int  nAsserts = 0;
  int  nFails   = 0;
  int  tbCycle  = 0;

  always #5 clk = ~clk;

  ctrl_status_disp #(.SCAN_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .insn_type  (insn_type),
    .insn_code  (insn_code),
    .insn_stage (insn_stage),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .code_err   (code_err)
  );

  // Rising edges since reset release; the negedge after edge k sees k.
  always @(posedge clk or posedge rst) begin
    if (rst) tbCycle <= 0;
    else     tbCycle <= tbCycle + 1;
  end

  // Reference glyph tables, active-high {g..a}.
  function automatic logic [6:0] mHex(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] mType(input logic [3:0] t);
    case (t)
      4'd0: return {1'b0, 7'h54};
      4'd1: return {1'b0, 7'h50};
      4'd2: return {1'b0, 7'h1E};
      4'd3: return {1'b0, 7'h06};
      default: return {1'b1, 7'h40};
    endcase
  endfunction

  function automatic logic [7:0] mCode(input logic [3:0] c);
    case (c)
      4'd0: return {1'b0, 7'h3F};
      4'd1: return {1'b0, 7'h38};
      4'd2: return {1'b0, 7'h6D};
      4'd3: return {1'b0, 7'h77};
      4'd4: return {1'b0, 7'h3E};
      4'd5: return {1'b0, 7'h5F};
      4'd6: return {1'b0, 7'h5C};
      4'd7: return {1'b0, 7'h1E};
      default: return {1'b1, 7'h40};
    endcase
  endfunction

  function automatic logic [7:0] mStage(input logic [2:0] s);
    case (s)
      3'd0: return {1'b0, 7'h06};
      3'd1: return {1'b0, 7'h5B};
      3'd2: return {1'b0, 7'h4F};
      3'd3: return {1'b0, 7'h66};
      3'd4: return {1'b0, 7'h6D};
      default: return {1'b1, 7'h40};
    endcase
  endfunction

  // Queue the four digit slots of one frame (digit 0 first, as scanned).
  task automatic pushFrame(input logic [3:0] t, input logic [3:0] c, input logic [2:0] s,
                           input logic [3:0] st, input int frameNo, input string tagp);
    logic [7:0] ty;
    logic [7:0] co;
    logic [7:0] sg;
    logic [6:0] g;
    logic       fe;
    logic       anyErr;
    logic       blank;
    logic [1:0] d;
    expT        e;
    ty = mType(t);
    co = mCode(c);
    sg = mStage(s);
    anyErr = ty[7] | co[7] | sg[7];
    for (int k = 0; k < 4; k++) begin
      d = 2'(k);
      case (d)
        2'd1:    begin g = sg[6:0]; fe = sg[7]; end
        2'd2:    begin g = co[6:0]; fe = co[7]; end
        2'd3:    begin g = ty[6:0]; fe = ty[7]; end
        default: begin g = mHex(st); fe = 1'b0; end
      endcase
      blank    = BLINK_BUILD && anyErr && fe && ((frameNo % 64) >= 32);
      e.tag    = $sformatf("%s_d%0d", tagp, k);
      e.an     = blank ? 4'b1111 : ~(4'b0001 << d);
      e.seg    = ~g;
      e.dp     = (d == 2'd0 && st == 4'hF) ? 1'b0 : 1'b1;
      e.err    = anyErr;
      e.chkSeg = !blank;
      sbQ.push_back(e);
    end
  endtask

  task automatic pushReset(input string tagp);
    expT e;
    e.tag    = tagp;
    e.an     = 4'b1110;
    e.seg    = 7'b1000000;
    e.dp     = 1'b1;
    e.err    = 1'b0;
    e.chkSeg = 1'b1;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input expT e);
    nAsserts++;
    assert (an_n === e.an) else begin
      nFails++;
      $error("[TB] FAIL %s an_n: observed %b expected %b", e.tag, an_n, e.an);
    end
    if (e.chkSeg) begin
      nAsserts++;
      assert (seg_n === e.seg) else begin
        nFails++;
        $error("[TB] FAIL %s seg_n: observed %b expected %b", e.tag, seg_n, e.seg);
      end
    end
    nAsserts++;
    assert (dp_n === e.dp) else begin
      nFails++;
      $error("[TB] FAIL %s dp_n: observed %b expected %b", e.tag, dp_n, e.dp);
    end
    nAsserts++;
    assert (code_err === e.err) else begin
      nFails++;
      $error("[TB] FAIL %s code_err: observed %b expected %b", e.tag, code_err, e.err);
    end
  endtask

  task automatic popAndCheck(output expT e);
    if (sbQ.size() == 0) begin
      nFails++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected at least 1");
      e.tag = "empty"; e.an = 4'bxxxx; e.seg = 7'bx; e.dp = 1'bx; e.err = 1'bx; e.chkSeg = 1'b1;
    end else begin
      e = sbQ.pop_front();
    end
  endtask

  // Advance to the negedge where tbCycle == n (no wait if already there).
  task automatic waitCycle(input int n);
    int guard;
    guard = 0;
    while (tbCycle != n && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (tbCycle != n) begin
      nFails++;
      $error("[TB] FAIL wait_cycle: observed %0d expected %0d", tbCycle, n);
    end
  endtask

  // Check nSlots digit slots starting at cycle start, every cycle of each.
  task automatic checkSlots(input int start, input int nSlots);
    expT e;
    waitCycle(start);
    for (int i = 0; i < nSlots * 4; i++) begin
      if (i > 0) @(negedge clk);
      if (i % 4 == 0) popAndCheck(e);
      checkOutput(e);
    end
  endtask

  // Drive new status inputs now and queue the frame that will show them.
  task automatic applyStimulus(input logic [3:0] t, input logic [3:0] c, input logic [2:0] s,
                               input logic [3:0] st, input string tagp, output int target);
    insn_type  = t;
    insn_code  = c;
    insn_stage = s;
    state      = st;
    target     = (tbCycle / FRAME_CYC + 1) * FRAME_CYC;
    pushFrame(t, c, s, st, target / FRAME_CYC, tagp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expT e;
    int  tgt;
    rst        = 1'b1;
    state      = 4'd0;
    insn_type  = 4'd0;
    insn_code  = 4'd0;
    insn_stage = 3'd0;
    repeat (3) @(negedge clk);

    $display("[TB] power-on reset values");
    pushReset("por");
    popAndCheck(e);
    checkOutput(e);

    $display("[TB] scan order after release, zero snapshot");
    rst = 1'b0;
    pushFrame(4'd0, 4'd0, 3'd0, 4'd0, 0, "scan0");
    checkSlots(0, 4);

    $display("[TB] decode type=1 code=3 stage=2 state=2");
    applyStimulus(4'd1, 4'd3, 3'd2, 4'd2, "decode", tgt);
    checkSlots(tgt, 4);

    $display("[TB] state change 2->5 during digit 1 slot");
    pushFrame(insn_type, insn_code, insn_stage, state, 2, "hold");
    checkSlots(32, 1);
    waitCycle(36);
    applyStimulus(4'd1, 4'd3, 3'd2, 4'd5, "changed", tgt);
    checkSlots(36, 3);
    checkSlots(tgt, 4);

    $display("[TB] invalid type=9 stage=6 state=F driven mid-frame");
    pushFrame(insn_type, insn_code, insn_stage, state, 4, "pre_err");
    checkSlots(64, 1);
    waitCycle(68);
    applyStimulus(4'd9, 4'd3, 3'd6, 4'hF, "invalid", tgt);
    checkSlots(68, 3);
    checkSlots(tgt, 4);

    $display("[TB] blink phase boundaries, frames 31/32/63/64");
    pushFrame(insn_type, insn_code, insn_stage, state, 31, "frm31");
    checkSlots(31 * FRAME_CYC, 4);
    pushFrame(insn_type, insn_code, insn_stage, state, 32, "frm32");
    checkSlots(32 * FRAME_CYC, 4);
    pushFrame(insn_type, insn_code, insn_stage, state, 63, "frm63");
    checkSlots(63 * FRAME_CYC, 4);
    pushFrame(insn_type, insn_code, insn_stage, state, 64, "frm64");
    checkSlots(64 * FRAME_CYC, 4);

    $display("[TB] reset asserted in digit 1 slot");
    pushFrame(insn_type, insn_code, insn_stage, state, 65, "pre_rst");
    checkSlots(65 * FRAME_CYC, 2);
    sbQ.delete();
    rst = 1'b1;
    #1;
    pushReset("midscan");
    popAndCheck(e);
    checkOutput(e);
    @(negedge clk);
    rst = 1'b0;
    pushFrame(4'd0, 4'd0, 3'd0, 4'd0, 0, "post_rst");
    checkSlots(0, 4);
    pushFrame(insn_type, insn_code, insn_stage, state, 1, "first_snap");
    checkSlots(FRAME_CYC, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
